// File: rtl/rr_arb.sv
// rr_arb: round-robin arbiter with registered one-hot and encoded grant outputs.
// Optional grant locking is enabled by defining RR_ARB_LOCK_EN. With it, a holder
// keeps the grant for up to HOLD_MAX consecutive cycles while it keeps requesting.
// Without it, arbitration happens every cycle and the holder rotates to lowest priority.
module rr_arb #(
  parameter int N        = 16,
  parameter int IDW      = $clog2(N),
  parameter int HOLD_MAX = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] id_q, id_d;
  logic           valid_q, valid_d;

`ifdef RR_ARB_LOCK_EN
  localparam int HW = $clog2(HOLD_MAX + 1);
  logic [HW-1:0]  hold_q, hold_d;
`endif

  logic [N-1:0]   candReq;
  logic [IDW-1:0] winId;
  logic [N-1:0]   winOneHot;
  logic           lockKeep;
  logic           doGrant;
  logic           doDrop;

  assign gnt       = gnt_q;
  assign gnt_id    = id_q;
  assign gnt_valid = valid_q;

  // Circular priority scan starting at p; index wrap is explicit so any N works.
  function automatic logic [IDW-1:0] pick(input logic [N-1:0] r, input logic [IDW-1:0] p);
    logic [IDW-1:0] w;
    logic [IDW-1:0] iv;
    logic           found;
    int             idx;
    w     = '0;
    found = 1'b0;
    for (int off = 0; off < N; off++) begin
      idx = int'(p) + off;
      if (idx >= N) idx = idx - N;
      iv = idx[IDW-1:0];
      if (!found && r[iv]) begin
        found = 1'b1;
        w     = iv;
      end
    end
    return w;
  endfunction

  // Pointer moves just past the winner, wrapping from N-1 back to 0.
  function automatic logic [IDW-1:0] nextPtr(input logic [IDW-1:0] w);
    if (int'(w) == N - 1) return '0;
    return w + IDW'(1);
  endfunction

  // Decide whether the current holder keeps its grant and which requests compete.
  always_comb begin
    lockKeep = 1'b0;
    candReq  = req;
`ifdef RR_ARB_LOCK_EN
    if (state_q == GRANT && req[id_q]) begin
      if (int'(hold_q) < HOLD_MAX - 1) begin
        lockKeep = 1'b1;
      end else if ((req & ~gnt_q) != '0) begin
        candReq = req & ~gnt_q;
      end
    end
`endif
    winId     = pick(candReq, ptr_q);
    winOneHot = {{(N-1){1'b0}}, 1'b1} << winId;
  end

  // Next-state logic: a new grant, a drop back to idle, or an unchanged locked grant.
  always_comb begin
    doGrant = 1'b0;
    doDrop  = 1'b0;
    case (state_q)
      IDLE:    doGrant = (req != '0);
      GRANT: begin
        doGrant = !lockKeep && (req != '0);
        doDrop  = !lockKeep && (req == '0);
      end
      default: doDrop = 1'b1;
    endcase

    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    valid_d = valid_q;
`ifdef RR_ARB_LOCK_EN
    hold_d  = hold_q;
    if (lockKeep) hold_d = hold_q + HW'(1);
`endif

    if (doGrant) begin
      state_d = GRANT;
      ptr_d   = nextPtr(winId);
      gnt_d   = winOneHot;
      id_d    = winId;
      valid_d = 1'b1;
`ifdef RR_ARB_LOCK_EN
      hold_d  = '0;
`endif
    end else if (doDrop) begin
      state_d = IDLE;
      gnt_d   = '0;
      id_d    = '0;
      valid_d = 1'b0;
`ifdef RR_ARB_LOCK_EN
      hold_d  = '0;
`endif
    end
  end

  // State and registered outputs; reset abandons any grant and restarts priority at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      id_q    <= '0;
      valid_q <= 1'b0;
`ifdef RR_ARB_LOCK_EN
      hold_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      valid_q <= valid_d;
`ifdef RR_ARB_LOCK_EN
      hold_q  <= hold_d;
`endif
    end
  end

endmodule

// File: tb/tb_rr_arb.sv
// tb_rr_arb: directed and randomized checks of rr_arb (N=16, HOLD_MAX=8) against
// a behavioural model that tracks holder, priority pointer and hold count as integers.
module tb_rr_arb;

  localparam int N        = 16;
  localparam int IDW      = 4;
  localparam int HOLD_MAX = 8;
`ifdef RR_ARB_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           gnt_valid;

  int compared   = 0;
  int mismatched = 0;

  int mHolder = -1;
  int mPtr    = 0;
  int mHc     = 0;

  rr_arb #(.N(N), .IDW(IDW), .HOLD_MAX(HOLD_MAX)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .gnt      (gnt),
    .gnt_id   (gnt_id),
    .gnt_valid(gnt_valid)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // First set bit scanning circularly from p, or -1 when nothing requests.
  function automatic int firstFrom(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // One clock step of the model, applied to the request vector seen at the edge.
  task automatic modelStep(input logic [N-1:0] r);
    logic [N-1:0] cand;
    int           w;
    cand = r;
    if (LOCK && mHolder >= 0 && r[mHolder]) begin
      if (mHc < HOLD_MAX - 1) begin
        mHc = mHc + 1;
        return;
      end
      cand[mHolder] = 1'b0;
      if (cand == '0) cand = r;
    end
    w = firstFrom(cand, mPtr);
    if (w < 0) begin
      mHolder = -1;
      mHc     = 0;
    end else begin
      mHolder = w;
      mPtr    = (w + 1) % N;
      mHc     = 0;
    end
  endtask

  // Model advances on every clock edge and clears at once on reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mHolder = -1;
      mPtr    = 0;
      mHc     = 0;
    end else begin
      modelStep(req);
    end
  end

  // Every falling edge, the DUT outputs must match what the model says is granted.
  always @(negedge clk) begin
    logic [N-1:0] eg;
    int           eid;
    bit           ev;
    ev  = (mHolder >= 0);
    eid = ev ? mHolder : 0;
    eg  = ev ? (16'(1) << mHolder) : '0;
    compared++;
    if (gnt !== eg || gnt_id !== 4'(eid) || gnt_valid !== ev) begin
      mismatched++;
      $display("[TB] FAIL model_cycle t=%0t got gnt=%h id=%0d valid=%b want gnt=%h id=%0d valid=%b",
               $time, gnt, gnt_id, gnt_valid, eg, eid, ev);
    end
`ifdef RR_ARB_LOCK_EN
    compared++;
    if (dut.hold_q !== 4'(mHc)) begin
      mismatched++;
      $display("[TB] FAIL model_hold t=%0t got hold=%0d want %0d", $time, dut.hold_q, mHc);
    end
`endif
  end

  // Hand-computed expectation of the outputs at this moment.
  task automatic checkOutput(input string name, input int expId, input bit expValid);
    logic [N-1:0] eg;
    eg = expValid ? (16'(1) << expId) : '0;
    compared++;
    if (gnt !== eg || gnt_id !== 4'(expId) || gnt_valid !== expValid) begin
      mismatched++;
      $display("[TB] FAIL %s t=%0t got gnt=%h id=%0d valid=%b want gnt=%h id=%0d valid=%b",
               name, $time, gnt, gnt_id, gnt_valid, eg, expId, expValid);
    end
  endtask

`ifdef RR_ARB_LOCK_EN
  task automatic checkHold(input string name, input int expHold);
    compared++;
    if (dut.hold_q !== 4'(expHold)) begin
      mismatched++;
      $display("[TB] FAIL %s t=%0t got hold=%0d want %0d", name, $time, dut.hold_q, expHold);
    end
  endtask
`endif

  // Drive a request vector, let one edge sample it, and return just after that edge.
  task automatic applyStimulus(input logic [N-1:0] r);
    req = r;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse spanning two edges; outputs must clear with no clock.
  task automatic doReset();
    rst = 1'b1;
    #1;
    checkOutput("rst_async", 0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("rst_held", 0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [N-1:0] prevReq;
    int           sel;

    // Reset with every requester active: nothing may be granted while reset is high.
    req = 16'hFFFF;
    #1 rst = 1'b1;
    #1 checkOutput("rst_ffff_async", 0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("rst_ffff_held", 0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(16'hFFFF);
    checkOutput("first_after_rst", 0, 1'b1);
    applyStimulus(16'hFFFF);
    checkOutput("second_after_rst", LOCK ? 0 : 1, 1'b1);

`ifndef RR_ARB_LOCK_EN
    // Two requesters at opposite ends alternate every cycle.
    doReset();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(16'h8001);
      checkOutput("alt_0_15", (i % 2 == 0) ? 0 : 15, 1'b1);
    end
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(16'h0006);
      checkOutput("alt_1_2", (i % 2 == 0) ? 1 : 2, 1'b1);
    end
`endif

    // A lone requester 0 keeps winning as the pointer wraps; dropping it clears the grant.
    doReset();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(16'h0001);
      checkOutput("lone_0", 0, 1'b1);
    end
    applyStimulus(16'h0000);
    checkOutput("lone_0_drop", 0, 1'b0);

`ifdef RR_ARB_LOCK_EN
    // Two persistent requesters swap the lock every HOLD_MAX cycles.
    doReset();
    for (int i = 0; i < 17; i++) begin
      applyStimulus(16'h0006);
      checkOutput("lock_swap", (i < 8 || i >= 16) ? 1 : 2, 1'b1);
    end

    // Holder releases early: the other requester takes over at once with a fresh count.
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(16'h0006);
      checkOutput("lock_pre_release", 1, 1'b1);
    end
    checkHold("lock_pre_release_hold", 2);
    applyStimulus(16'h0004);
    checkOutput("lock_release", 2, 1'b1);
    checkHold("lock_release_hold", 0);

    // Reset in the middle of a hold, then the same requester wins again from scratch.
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(16'h0020);
      checkOutput("lock_hold_5", 5, 1'b1);
    end
    rst = 1'b1;
    #1;
    checkOutput("lock_rst_async", 0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("lock_rst_held", 0, 1'b0);
    rst = 1'b0;
    applyStimulus(16'h0020);
    checkOutput("lock_after_rst", 5, 1'b1);
    checkHold("lock_after_rst_hold", 0);
`endif

    // Randomized traffic with sticky requests and occasional mid-cycle resets.
    prevReq = '0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        #2 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
      end
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      prevReq = '0;
      else if (sel <= 2) prevReq = 16'(1) << $urandom_range(0, N - 1);
      else if (sel <= 5) prevReq = 16'($urandom);
      applyStimulus(prevReq);
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rr_arb.md
RR_ARB -- requirements
Module: rr_arb

Interface
REQ-001 Parameter: N, 16, number of requesters (2..64).
REQ-002 Parameter: IDW, $clog2(N), width of encoded grant index.
REQ-003 Parameter: HOLD_MAX, 8, maximum consecutive cycles one holder keeps a locked grant (>=1).
REQ-004 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port: rst  input  1  reset; asynchronous, active-high.
REQ-006 Port: req  input  N  request vector; bit i high = requester i wants the resource.
REQ-007 Port: gnt  output  N  registered one-hot grant; all-zero when no grant.
REQ-008 Port: gnt_id  output  IDW  registered binary index of the set gnt bit; 0 when gnt_valid=0.
REQ-009 Port: gnt_valid  output  1  registered; high exactly when gnt is non-zero.

Function
REQ-010 Internal state: priority pointer ptr[IDW-1:0], state in {IDLE, GRANT}, hold counter hold_cnt (width $clog2(HOLD_MAX+1)).
REQ-011 Arbitration: winner is the first set req bit scanning indices ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (wrap mod N, valid for non-power-of-two N).
REQ-012 Latency: req sampled at edge k, resulting gnt/gnt_id/gnt_valid visible after edge k (one-cycle registered latency); no combinational path req->gnt.
REQ-013 On every new grant: ptr <= winner+1, with winner=N-1 wrapping to 0; hold_cnt <= 0; state <= GRANT.
REQ-014 IDLE: req=0 -> outputs stay zero, ptr unchanged; req!=0 -> arbitrate per REQ-011.
REQ-015 GRANT with req=0 -> gnt=0, gnt_id=0, gnt_valid=0, state <= IDLE, ptr unchanged.
REQ-016 gnt, gnt_id, gnt_valid shall always be mutually consistent (single hot bit at gnt_id, or all zero).
REQ-017 A requester whose req bit is 0 at the sampling edge shall never be granted for the following cycle.

Reset
REQ-018 rst=1 immediately (without clock) forces gnt=0, gnt_id=0, gnt_valid=0, ptr=0, hold_cnt=0, state=IDLE.
REQ-019 Reset asserted mid-grant abandons the grant; first arbitration after rst deasserts uses ptr=0.
REQ-020 Deassertion of rst takes effect on the next rising clk; no grant issues in the cycle rst is high.

Configuration
REQ-021 Macro RR_ARB_LOCK_EN selects grant locking.
REQ-022 Without RR_ARB_LOCK_EN: re-arbitrate every cycle in both states per REQ-011/REQ-013; hold_cnt unused; a continuously requesting holder loses priority after each grant.
REQ-023 With RR_ARB_LOCK_EN, in GRANT: req[gnt_id]=1 and hold_cnt<HOLD_MAX-1 -> grant unchanged, hold_cnt+1, ptr unchanged.
REQ-024 With RR_ARB_LOCK_EN: req[gnt_id]=0 (release) -> arbitrate same edge among remaining req; none -> REQ-015.
REQ-025 With RR_ARB_LOCK_EN: req[gnt_id]=1 and hold_cnt=HOLD_MAX-1 -> arbitrate with holder masked out; no other requester -> re-grant holder, hold_cnt <= 0, ptr <= holder+1.
REQ-026 With RR_ARB_LOCK_EN and HOLD_MAX=1 behaviour equals REQ-022.

Verification (N=16, HOLD_MAX=8)
REQ-027 rst=1 with req=16'hFFFF -> gnt=0, gnt_id=0, gnt_valid=0 asynchronously; after release first grant gnt_id=0.
REQ-028 No lock, req=16'h8001 held -> gnt_id sequence 0,15,0,15,... one per cycle, gnt_valid=1 from first edge after req.
REQ-029 No lock, req=16'h0001 held -> gnt_id=0 every cycle (wrap ptr 1..15..0 correct); req->0 -> next cycle gnt_valid=0.
REQ-030 Lock, req=16'h0006 held -> gnt_id=1 for 8 cycles, then gnt_id=2 for 8 cycles, then 1 again.
REQ-031 Lock, req=16'h0006, req[1] dropped after 3 cycles of grant -> next cycle gnt_id=2, hold_cnt=0.
REQ-032 Lock, gnt_id=5 active, rst pulsed one cycle mid-hold -> outputs zero immediately; with req=16'h0020 after release -> gnt_id=5 one edge later, hold_cnt=0.
